// File: rtl/mul_pkg.sv
// Shared types for the bit-serial multiplier.
// Holds the FSM state encoding and the default operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/mul_serialized.sv
// Bit-serial shift-and-add multiplier with ready/valid on both sides.
// Optional MUL_SERIALIZED_EARLY_EXIT_EN: leave MUL once remaining multiplier bits are zero.
module mul_serialized
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int IW = $clog2(WIDTH + 1);

    mul_state_t         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               mul_exit;

`ifdef MUL_SERIALIZED_EARLY_EXIT_EN
    assign mul_exit = (idx_q == IW'(WIDTH)) || (b_q == '0);
`else
    assign mul_exit = (idx_q == IW'(WIDTH));
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = {{WIDTH{1'b0}}, a_i};
                    b_d     = b_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mul_exit) begin
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pure state decodes: nothing here depends on ready_i.
    always_comb begin
        ready_o   = (state_q == IDLE);
        valid_o   = (state_q == DONE);
        product_o = valid_o ? acc_q : '0;
    end

endmodule

// File: tb/tb_mul_serialized.sv
// Randomized self-checking bench for mul_serialized (WIDTH=32).
// Reference: plain 64-bit product and latency from the multiplier's top set bit.
module tb_mul_serialized;

    localparam int W = 32;

    logic            clk;
    logic            rst_ni;
    logic            start_i;
    logic [W-1:0]    a_i;
    logic [W-1:0]    b_i;
    logic            ready_o;
    logic [2*W-1:0]  product_o;
    logic            valid_o;
    logic            ready_i;

    int checks = 0;
    int errors = 0;

    mul_serialized #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .ready_o   (ready_o),
        .product_o (product_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_SERIALIZED_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 2;
        return 1;
`else
        return W + 1;
`endif
    endfunction

    // Caller is at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bp, input bit toggle);
        logic [63:0] exp_p;
        int n;
        int bad;
        exp_p = 64'(a) * 64'(b);
        check("ready_idle", 64'(ready_o), 64'd1);
        ready_i = 1'b0;
        start_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        bad = 0;
        while (1) begin
            n++;
            @(posedge clk);
            if (toggle) begin
                #1;
                a_i = $urandom;
                b_i = $urandom;
                start_i = 1'($urandom);
            end
            @(negedge clk);
            if (valid_o) break;
            if (product_o != '0 || ready_o) bad++;
            if (n >= 100) begin
                check("timeout", 64'd0, 64'd1);
                start_i = 1'b0;
                return;
            end
        end
        check("busy_outputs", 64'(bad), 64'd0);
        check("latency", 64'(n), 64'(exp_lat(b)));
        check("product", product_o, exp_p);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1 start_i = 1'($urandom);
            a_i = $urandom;
            @(negedge clk);
            check("hold_valid", 64'(valid_o), 64'd1);
            check("hold_product", product_o, exp_p);
            check("hold_ready", 64'(ready_o), 64'd0);
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        @(negedge clk);
        check("post_valid", 64'(valid_o), 64'd0);
        check("post_ready", 64'(ready_o), 64'd1);
        check("post_product", product_o, 64'd0);
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        ready_i = 1'b0;
        #12 rst_ni = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_product", product_o, 64'd0);

        run_op(32'd3, 32'd5, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        start_i = 1'b1;
        a_i = 32'd7;
        b_i = 32'd9;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_product", product_o, 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        run_op(32'd2, 32'd2, 0, 1'b0);

        run_op(32'd6, 32'd7, 2, 1'b1);
        run_op(32'd9, 32'd0, 0, 1'b0);
        run_op(32'd9, 32'd1, 0, 1'b0);
        run_op(32'h0000_0005, 32'h8000_0000, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 32);
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
